fetch_unit: RTL and testbench

//  Instruction fetch and sequencing front end. Drives the 9-bit instruction word into control_logic.

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: control/datapath side (master) and fetch unit (slave).
// Groups sequencing controls, redirect/LUT writes, imem port and decoder-facing outputs.
interface fetch_unit_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  start_pc;
  logic             done;
  logic             stall;
  logic             redirect_en;
  logic [1:0]       redirect_kind;
  logic [PC_W-1:0]  redirect_val;
  logic             call_en;
  logic             lut_we;
  logic [1:0]       lut_idx;
  logic [PC_W-1:0]  lut_data;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       imem_rdata;
  logic [8:0]       instr_o;
  logic             instr_valid;
  logic [PC_W-1:0]  pc_o;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, start_pc, done, stall, redirect_en, redirect_kind, redirect_val,
           call_en, lut_we, lut_idx, lut_data, imem_rdata,
    input  imem_addr, instr_o, instr_valid, pc_o, halted, retired
  );

  modport slave (
    input  start, start_pc, done, stall, redirect_en, redirect_kind, redirect_val,
           call_en, lut_we, lut_idx, lut_data, imem_rdata,
    output imem_addr, instr_o, instr_valid, pc_o, halted, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: PC, long-jump table, link register, retired counter.
// Zero-bubble redirects via combinational imem_addr; stall re-reads the current word.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_link;
  logic [PC_W-1:0]  r_lut [4];
  logic [CNT_W-1:0] r_retired;

  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_next;
  logic [PC_W-1:0]  w_pc_inc;
  logic             w_run;
  logic             w_take_redirect;

  assign w_run           = (r_state == S_RUN);
  assign w_pc_inc        = r_pc + PC_W'(1);
  assign w_take_redirect = w_run && !bus.done && !bus.stall && bus.redirect_en;

  always_comb begin
    w_target = '0;
    unique case (bus.redirect_kind)
      2'd0: w_target = r_pc + bus.redirect_val;
      2'd1: w_target = bus.redirect_val;
      2'd2: w_target = r_lut[bus.redirect_val[1:0]];
      2'd3: w_target = r_link;
      default: w_target = '0;
    endcase
  end

  // Halt wins over stall, stall wins over redirect.
  always_comb begin
    w_next = bus.start_pc;
    if (w_run) begin
      if (bus.done)             w_next = bus.start_pc;
      else if (bus.stall)       w_next = r_pc;
      else if (bus.redirect_en) w_next = w_target;
      else                      w_next = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_link    <= '0;
      r_retired <= '0;
      for (int i = 0; i < 4; i++) r_lut[i] <= '0;
    end else begin
      // Table writes land after the same-cycle LJP read, so that read sees the old entry.
      if (bus.lut_we) r_lut[bus.lut_idx] <= bus.lut_data;

      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            r_state   <= S_RUN;
            r_pc      <= bus.start_pc;
            r_retired <= '0;
          end
        end
        S_RUN: begin
          r_pc <= w_next;
          if (bus.done) r_state <= S_HALT;
          if ((bus.done || !bus.stall) && (r_retired != '1))
            r_retired <= r_retired + CNT_W'(1);
          if (w_take_redirect && bus.call_en) r_link <= w_pc_inc;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_addr   = w_next;
  assign bus.instr_valid = w_run;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.instr_o     = w_run ? bus.imem_rdata : 9'h000;
  assign bus.pc_o        = r_pc;
  assign bus.retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance plus a narrow-counter instance for saturation.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   exp_ret;

  fetch_unit_if #(.PC_W(10), .CNT_W(16)) bus ();
  fetch_unit_if #(.PC_W(4),  .CNT_W(4))  sbus ();

  fetch_unit #(.PC_W(10), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_unit #(.PC_W(4),  .CNT_W(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] word(input logic [9:0] a);
    return a[8:0] ^ 9'h0A5;
  endfunction

  always @(posedge clk) bus.imem_rdata  <= word(bus.imem_addr);
  always @(posedge clk) sbus.imem_rdata <= word({6'b0, sbus.imem_addr});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run(input logic [9:0] pc);
    check("pc_o", 32'(bus.pc_o), 32'(pc));
    check("instr_valid", 32'(bus.instr_valid), 32'd1);
    check("instr_o", 32'(bus.instr_o), 32'(word(pc)));
    check("retired", 32'(bus.retired), 32'(exp_ret));
  endtask

  task automatic adv(input logic [9:0] pc);
    if (!bus.stall) exp_ret++;
    step();
    check_run(pc);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; exp_ret = 0;
    rst_n = 1'b0;
    bus.start = 0; bus.start_pc = '0; bus.done = 0; bus.stall = 0;
    bus.redirect_en = 0; bus.redirect_kind = '0; bus.redirect_val = '0; bus.call_en = 0;
    bus.lut_we = 0; bus.lut_idx = '0; bus.lut_data = '0;
    sbus.start = 0; sbus.start_pc = '0; sbus.done = 0; sbus.stall = 0;
    sbus.redirect_en = 0; sbus.redirect_kind = '0; sbus.redirect_val = '0; sbus.call_en = 0;
    sbus.lut_we = 0; sbus.lut_idx = '0; sbus.lut_data = '0;
    #12;
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_instr", 32'(bus.instr_o), 32'd0);
    check("rst_pc", 32'(bus.pc_o), 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Start and sequential fetch
    bus.start_pc = 10'h010; bus.start = 1;
    step();
    bus.start = 0; exp_ret = 0;
    check_run(10'h010);
    adv(10'h011); adv(10'h012); adv(10'h013); adv(10'h014);

    // REL backwards, then ABS
    bus.redirect_en = 1; bus.redirect_kind = 2'd0; bus.redirect_val = 10'h3FD;
    adv(10'h011);
    bus.redirect_kind = 2'd1; bus.redirect_val = 10'h200;
    adv(10'h200);

    // LJP with call, then RET
    bus.redirect_val = 10'h030; bus.lut_we = 1; bus.lut_idx = 2'd2; bus.lut_data = 10'h3F0;
    adv(10'h030);
    bus.lut_we = 0;
    bus.redirect_kind = 2'd2; bus.redirect_val = 10'h002; bus.call_en = 1;
    adv(10'h3F0);
    bus.call_en = 0; bus.redirect_en = 0;
    adv(10'h3F1);
    bus.redirect_en = 1; bus.redirect_kind = 2'd3;
    adv(10'h031);

    // LJP reading an entry written the same cycle sees the old value
    bus.redirect_kind = 2'd2; bus.redirect_val = 10'h001;
    bus.lut_we = 1; bus.lut_idx = 2'd1; bus.lut_data = 10'h155;
    adv(10'h000);
    bus.lut_we = 0;
    adv(10'h155);

    // Stall holds instruction while a REL is pending
    bus.redirect_kind = 2'd1; bus.redirect_val = 10'h020;
    adv(10'h020);
    bus.redirect_kind = 2'd0; bus.redirect_val = 10'h008; bus.stall = 1;
    repeat (3) adv(10'h020);
    bus.stall = 0;
    adv(10'h028);

    // Wrap at top of address space
    bus.redirect_kind = 2'd1; bus.redirect_val = 10'h3FF;
    adv(10'h3FF);
    bus.redirect_en = 0;
    adv(10'h000);

    // start while running is ignored
    bus.start = 1; bus.start_pc = 10'h050;
    adv(10'h001);
    bus.start = 0;

    // done beats redirect; halt instruction is counted
    bus.done = 1; bus.redirect_en = 1; bus.redirect_kind = 2'd1; bus.redirect_val = 10'h123;
    exp_ret++;
    step();
    bus.done = 0; bus.redirect_en = 0;
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_valid", 32'(bus.instr_valid), 32'd0);
    check("halt_instr", 32'(bus.instr_o), 32'd0);
    check("halt_retired", 32'(bus.retired), 32'(exp_ret));
    step();
    check("halt_hold", 32'(bus.halted), 32'd1);
    check("halt_pc", 32'(bus.pc_o), 32'h050);
    check("halt_ret_hold", 32'(bus.retired), 32'(exp_ret));

    // Restart from HALT
    bus.start_pc = 10'h100; bus.start = 1;
    step();
    bus.start = 0; exp_ret = 0;
    check_run(10'h100);
    check("restart_halted", 32'(bus.halted), 32'd0);
    adv(10'h101);

    // Asynchronous reset mid-run, no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_halted", 32'(bus.halted), 32'd0);
    check("arst_instr", 32'(bus.instr_o), 32'd0);
    check("arst_pc", 32'(bus.pc_o), 32'd0);
    check("arst_retired", 32'(bus.retired), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // RET with unwritten link goes to 0
    bus.start_pc = 10'h040; bus.start = 1;
    step();
    bus.start = 0; exp_ret = 0;
    check_run(10'h040);
    bus.redirect_en = 1; bus.redirect_kind = 2'd3;
    adv(10'h000);
    bus.redirect_en = 0;

    // Counter saturation on the narrow instance
    sbus.start_pc = 4'h3; sbus.start = 1;
    step();
    sbus.start = 0;
    check("sat_start", 32'(sbus.retired), 32'd0);
    repeat (14) step();
    check("sat_14", 32'(sbus.retired), 32'd14);
    repeat (6) step();
    check("sat_max", 32'(sbus.retired), 32'h0F);
    check("sat_pc", 32'(sbus.pc_o), 32'((4'h3 + 4'd4) & 4'hF));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
